// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths, frame constants and sample type for the DAC stream sequencer
package audio_pkg;

    localparam int AUDIO_SAMPLE_W    = 16;
    localparam int STEREO_FRAME_BITS = 2 * AUDIO_SAMPLE_W;

    // Lowest legal frame length (one bit of slack beyond a full stereo word)
    // and lowest divider that still leaves setup time for the ser-des.
    localparam int MIN_FRAME_BCLKS = 33;
    localparam int MIN_BCLK_DIV    = 4;
    localparam int MAX_FRAME_BCLKS = 256;
    localparam int MAX_BCLK_DIV    = 255;

    typedef struct packed {
        logic [AUDIO_SAMPLE_W-1:0] left;
        logic [AUDIO_SAMPLE_W-1:0] right;
    } stereo_sample_t;

    function automatic stereo_sample_t pack_sample(input logic [AUDIO_SAMPLE_W-1:0] left,
                                                   input logic [AUDIO_SAMPLE_W-1:0] right);
        stereo_sample_t s;
        s.left  = left;
        s.right = right;
        return s;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - small synchronous FIFO holding stereo samples
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = STEREO_FRAME_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             w_push;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_nxt;

    // Requests are ignored when they cannot be honoured, so callers may be loose.
    assign w_push = push && !r_full;
    assign w_pop  = pop && (r_level != '0);

    // Occupancy is tracked separately from the pointers, which simply wrap.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    // Storage, pointers, occupancy and a registered full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;
    assign empty = (r_level == '0);
    assign full  = r_full;

endmodule

// File: rtl/audio_dac_stream_sequencer.sv
// rtl/audio_dac_stream_sequencer.sv - bit clock, frame strobe and sample presentation for the CODEC ser-des
module audio_dac_stream_sequencer
    import audio_pkg::*;
#(
    parameter int BCLK_DIV         = 4,
    parameter int FRAME_BCLKS      = 64,
    parameter int FIFO_DEPTH       = 4,
    parameter int UNDERFLOW_REPEAT = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          snk_valid,
    output logic                          snk_ready,
    input  logic [AUDIO_SAMPLE_W-1:0]     snk_data_L,
    input  logic [AUDIO_SAMPLE_W-1:0]     snk_data_R,
    output logic                          shift_clk,
    output logic                          dac_adc_valid,
    output logic [AUDIO_SAMPLE_W-1:0]     dac_data_L,
    output logic [AUDIO_SAMPLE_W-1:0]     dac_data_R,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underflow_cnt
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(FRAME_BCLKS);

    generate
        if (BCLK_DIV < MIN_BCLK_DIV || BCLK_DIV > MAX_BCLK_DIV) begin : g_bad_bclk_div
            $error("BCLK_DIV out of legal range");
        end
        if (FRAME_BCLKS < MIN_FRAME_BCLKS || FRAME_BCLKS > MAX_FRAME_BCLKS) begin : g_bad_frame
            $error("FRAME_BCLKS out of legal range");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 in 2..16");
        end
    endgenerate

    logic [DIV_W-1:0]          r_div_cnt;
    logic [BIT_W-1:0]          r_bit_cnt;
    logic                      r_shift_clk;
    logic                      r_dac_valid;
    logic [AUDIO_SAMPLE_W-1:0] r_dac_L;
    logic [AUDIO_SAMPLE_W-1:0] r_dac_R;
    logic [15:0]               r_underflow_cnt;

    logic                      w_div_tc;
    logic                      w_bit_last;
    logic                      w_frame_start;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    stereo_sample_t            w_wr_sample;
    stereo_sample_t            w_rd_sample;

    assign w_div_tc   = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    assign w_bit_last = (r_bit_cnt == BIT_W'(FRAME_BCLKS - 1));

    // The strobe rides the rising bit-clock edge of the last bit period, half a
    // bit before the falling edge the ser-des treats as frame start.
    assign w_frame_start = enable && w_div_tc && !r_shift_clk && w_bit_last;

    // snk_ready comes from the FIFO's registered full flag, so a pop in the
    // full cycle only reopens the sink on the following cycle.
    assign w_push      = snk_valid && snk_ready;
    assign w_pop       = w_frame_start && !w_fifo_empty;
    assign w_wr_sample = pack_sample(snk_data_L, snk_data_R);

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (STEREO_FRAME_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (w_wr_sample),
        .rdata   (w_rd_sample),
        .level   (fifo_level),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    // Half-period divider, bit clock and bit counter; disabling abandons the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt   <= '0;
            r_shift_clk <= 1'b0;
            r_bit_cnt   <= '0;
        end else if (!enable) begin
            r_div_cnt   <= '0;
            r_shift_clk <= 1'b0;
            r_bit_cnt   <= '0;
        end else if (w_div_tc) begin
            r_div_cnt   <= '0;
            r_shift_clk <= ~r_shift_clk;
            if (r_shift_clk) begin
                r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + BIT_W'(1);
            end
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // One-clock frame-start strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dac_valid <= 1'b0;
        end else begin
            r_dac_valid <= w_frame_start;
        end
    end

    // Sample presented to the ser-des, refreshed on the strobe edge and held between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dac_L <= '0;
            r_dac_R <= '0;
        end else if (w_frame_start) begin
            if (!w_fifo_empty) begin
                r_dac_L <= w_rd_sample.left;
                r_dac_R <= w_rd_sample.right;
            end else if (UNDERFLOW_REPEAT == 0) begin
                r_dac_L <= '0;
                r_dac_R <= '0;
            end
        end
    end

    // Saturating count of frames that found the FIFO empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow_cnt <= '0;
        end else if (w_frame_start && w_fifo_empty && (r_underflow_cnt != 16'hFFFF)) begin
            r_underflow_cnt <= r_underflow_cnt + 16'd1;
        end
    end

    assign snk_ready     = !w_fifo_full;
    assign shift_clk     = r_shift_clk;
    assign dac_adc_valid = r_dac_valid;
    assign dac_data_L    = r_dac_L;
    assign dac_data_R    = r_dac_R;
    assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_audio_dac_stream_sequencer.sv
// tb/tb_audio_dac_stream_sequencer.sv - scoreboard bench for the DAC stream sequencer (zero and repeat policies)
module tb_audio_dac_stream_sequencer;

    localparam int D     = 4;
    localparam int F     = 64;
    localparam int DEPTH = 4;
    localparam int FIRST = (2 * F - 1) * D;
    localparam int FRAME = 2 * F * D;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        snk_valid = 1'b0;
    logic [15:0] s_l = '0;
    logic [15:0] s_r = '0;

    logic        rdy0, rdy1, sclk0, sclk1, v0, v1;
    logic [15:0] l0, r0, l1, r1, uc0, uc1;
    logic [2:0]  lvl0, lvl1;

    always #5 clk = ~clk;

    audio_dac_stream_sequencer #(
        .BCLK_DIV(D), .FRAME_BCLKS(F), .FIFO_DEPTH(DEPTH), .UNDERFLOW_REPEAT(0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .snk_valid(snk_valid), .snk_ready(rdy0),
        .snk_data_L(s_l), .snk_data_R(s_r), .shift_clk(sclk0), .dac_adc_valid(v0),
        .dac_data_L(l0), .dac_data_R(r0), .fifo_level(lvl0), .underflow_cnt(uc0)
    );

    audio_dac_stream_sequencer #(
        .BCLK_DIV(D), .FRAME_BCLKS(F), .FIFO_DEPTH(DEPTH), .UNDERFLOW_REPEAT(1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .snk_valid(snk_valid), .snk_ready(rdy1),
        .snk_data_L(s_l), .snk_data_R(s_r), .shift_clk(sclk1), .dac_adc_valid(v1),
        .dac_data_L(l1), .dac_data_R(r1), .fifo_level(lvl1), .underflow_cnt(uc1)
    );

    typedef struct {
        int          cyc;
        logic [15:0] l0, r0, l1, r1, uc;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mq[$];
    int          cyc = 0;
    int          en_cnt = 0;
    logic [15:0] ml0 = '0, mr0 = '0, ml1 = '0, mr1 = '0, mucnt = '0;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 40) $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: strobes every FRAME enabled clocks, first one FIRST clocks after enable.
    initial begin
        logic [31:0] s;
        bit          ready_pre;
        exp_t        e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                mq.delete();
                en_cnt = 0;
                ml0 = '0; mr0 = '0; ml1 = '0; mr1 = '0; mucnt = '0;
            end else begin
                ready_pre = (mq.size() < DEPTH);
                en_cnt = enable ? en_cnt + 1 : 0;
                if (enable && en_cnt >= FIRST && ((en_cnt - FIRST) % FRAME) == 0) begin
                    if (mq.size() > 0) begin
                        s = mq.pop_front();
                        ml0 = s[31:16]; mr0 = s[15:0];
                        ml1 = s[31:16]; mr1 = s[15:0];
                    end else begin
                        ml0 = '0; mr0 = '0;
                        if (mucnt != 16'hFFFF) mucnt = mucnt + 16'd1;
                    end
                    e.cyc = cyc; e.l0 = ml0; e.r0 = mr0; e.l1 = ml1; e.r1 = mr1; e.uc = mucnt;
                    expq.push_back(e);
                end
                if (snk_valid && ready_pre) mq.push_back({s_l, s_r});
            end
        end
    end

    // Monitor: compares both DUTs against the model on the falling edge.
    initial begin
        bit   exp_now;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("shift_clk0", 32'(sclk0), 32'((en_cnt / D) % 2));
                chk("shift_clk1", 32'(sclk1), 32'((en_cnt / D) % 2));
                chk("fifo_level0", 32'(lvl0), 32'(mq.size()));
                chk("fifo_level1", 32'(lvl1), 32'(mq.size()));
                chk("snk_ready0", 32'(rdy0), 32'(mq.size() != DEPTH));
                chk("snk_ready1", 32'(rdy1), 32'(mq.size() != DEPTH));
                chk("hold_L0", 32'(l0), 32'(ml0));
                chk("hold_R1", 32'(r1), 32'(mr1));
                exp_now = (expq.size() > 0) && (expq[0].cyc == cyc);
                chk("strobe0", 32'(v0), 32'(exp_now));
                chk("strobe1", 32'(v1), 32'(exp_now));
                if (exp_now) begin
                    e = expq.pop_front();
                    chk("frame_L0", 32'(l0), 32'(e.l0));
                    chk("frame_R0", 32'(r0), 32'(e.r0));
                    chk("frame_L1", 32'(l1), 32'(e.l1));
                    chk("frame_R1", 32'(r1), 32'(e.r1));
                    chk("underflow_cnt0", 32'(uc0), 32'(e.uc));
                    chk("underflow_cnt1", 32'(uc1), 32'(e.uc));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic push_sample(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        while (!rdy0 && n < 2000) begin
            tick(1);
            n++;
        end
        chk("push_ready_timeout", 32'(rdy0), 32'd1);
        snk_valid = 1'b1; s_l = l; s_r = r;
        tick(1);
        snk_valid = 1'b0;
    endtask

    task automatic wait_strobe(input int budget);
        int n = 0;
        while (!v0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_timeout", 32'(v0), 32'd1);
        #2;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_shift_clk", {31'd0, sclk0 | sclk1}, 32'd0);
        chk("rst_valid", {31'd0, v0 | v1}, 32'd0);
        chk("rst_data0", {l0, r0}, 32'd0);
        chk("rst_data1", {l1, r1}, 32'd0);
        chk("rst_ready", {30'd0, rdy0, rdy1}, 32'd3);
        chk("rst_level", {26'd0, lvl0, lvl1}, 32'd0);
        chk("rst_ucnt", {uc0, uc1}, 32'd0);
    endtask

    initial begin
        logic [15:0] cnt;
        bit          r_seen;
        int          rate;
        // reset state
        tick(3);
        chk_reset_outputs();
        reset_n = 1'b1;
        tick(2);

        // 1: free-running with no source
        enable = 1'b1;
        tick(3 * FRAME + 20);
        enable = 1'b0;
        tick(5);

        // 2: four samples queued before the first strobe, fifth strobe underflows
        for (int n = 1; n <= 4; n++) push_sample(16'(16'h1111 * n), 16'(16'h2222 * n));
        tick(2);
        enable = 1'b1;
        tick(5 * FRAME + 20);

        // 3: single sample, then two underflows (repeat policy on u_dut1)
        push_sample(16'hABCD, 16'h1234);
        tick(3 * FRAME);

        // 4: continuous source with incrementing data
        cnt = 16'd1;
        snk_valid = 1'b1;
        for (int i = 0; i < 6 * FRAME; i++) begin
            s_l = cnt; s_r = ~cnt;
            r_seen = rdy0;
            tick(1);
            if (r_seen) cnt = cnt + 16'd1;
        end
        snk_valid = 1'b0;

        // 5: abandon a frame around bit 20, re-enable after 100 clocks
        wait_strobe(FRAME + 10);
        tick(D + 20 * 2 * D + D);
        enable = 1'b0;
        tick(100);
        enable = 1'b1;
        tick(FRAME + 20);

        // 6: asynchronous reset mid-frame with samples queued
        enable = 1'b0;
        tick(2);
        for (int i = 0; i < 3 && lvl0 < 3'd3; i++) push_sample(16'h5A00 + 16'(i), 16'hA500 + 16'(i));
        enable = 1'b1;
        tick(200);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        tick(3);
        enable = 1'b0;
        reset_n = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(FRAME + 20);

        // random traffic with varying source rates and occasional enable drops
        for (int seg = 0; seg < 10; seg++) begin
            case ($urandom_range(0, 4))
                0: rate = 0;
                1: rate = 1;
                2: rate = 4;
                3: rate = 50;
                default: rate = 1000;
            endcase
            for (int i = 0; i < 2048; i++) begin
                snk_valid = ($urandom_range(0, 999) < rate);
                s_l = 16'($urandom);
                s_r = 16'($urandom);
                if ($urandom_range(0, 2999) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 99) == 0) enable = 1'b1;
                tick(1);
            end
        end
        snk_valid = 1'b0;
        enable = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
